// File: rtl/ste_shift_pkg.sv
// rtl/ste_shift_pkg.sv - shared types and parameter checks for the shift engine
package ste_shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ste_shift_state_t;

    // Only 1, 2 or 4 lanes map onto the SPI/DSPI/QSPI PHYs this engine feeds.
    function automatic bit lanes_ok(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4);
    endfunction

endpackage

// File: rtl/ste_shift_engine_if.sv
// rtl/ste_shift_engine_if.sv - parallel load and receive-word channel of the shift engine
interface ste_shift_engine_if #(
    parameter int SHIFT_W = 24
);
    logic               msb_first_i;
    logic               ld_valid_i;
    logic [SHIFT_W-1:0] ld_data_i;
    logic               ld_ready_o;
    logic               rx_valid_o;
    logic [SHIFT_W-1:0] rx_data_o;

    modport master (
        output msb_first_i, ld_valid_i, ld_data_i,
        input  ld_ready_o, rx_valid_o, rx_data_o
    );

    modport slave (
        input  msb_first_i, ld_valid_i, ld_data_i,
        output ld_ready_o, rx_valid_o, rx_data_o
    );
endinterface

// File: rtl/ste_shift_cnt.sv
// rtl/ste_shift_cnt.sv - beat down-counter with load, decrement, clear and last-beat flag
module ste_shift_cnt #(
    parameter int               CNT_W    = 5,
    parameter logic [CNT_W-1:0] LOAD_VAL = '1
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/ste_shift_engine.sv
// rtl/ste_shift_engine.sv - full-duplex parallel-to-serial / serial-to-parallel shift engine
module ste_shift_engine
    import ste_shift_pkg::*;
#(
    parameter int SHIFT_W = 24,
    parameter int LANES   = 1
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             shift_en_i,
    input  logic [LANES-1:0] din_i,
    output logic [LANES-1:0] dout_o,
    output logic             busy_o,
    ste_shift_engine_if.slave ld_if
);
    localparam int               BEATS   = SHIFT_W / LANES;
    localparam int               CNT_W   = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);

    if (!lanes_ok(LANES) || ((SHIFT_W % LANES) != 0)) begin : g_bad_cfg
        $error("ste_shift_engine: LANES must be 1, 2 or 4 and divide SHIFT_W");
    end

    ste_shift_state_t   state_q;
    logic [SHIFT_W-1:0] shreg_q;
    logic [SHIFT_W-1:0] shreg_d;
    logic               dir_q;
    logic [SHIFT_W-1:0] rx_data_q;
    logic               rx_valid_q;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_last;
    logic               load_fire;
    logic               beat;

    assign load_fire = (state_q == IDLE) && ld_if.ld_valid_i;
    // The nonzero guard keeps the counter from ever wrapping below zero.
    assign beat      = (state_q == SHIFT) && shift_en_i && (cnt != '0);

    assign shreg_d = dir_q ? {shreg_q[SHIFT_W-LANES-1:0], din_i}
                           : {din_i, shreg_q[SHIFT_W-1:LANES]};

    ste_shift_cnt #(
        .CNT_W    (CNT_W),
        .LOAD_VAL (BEATS_C)
    ) u_cnt (
        .clk     (clk),
        .reset_i (reset_i),
        .clr_i   (clr_i),
        .load_i  (load_fire),
        .dec_i   (beat),
        .cnt_o   (cnt),
        .last_o  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            dir_q      <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else if (clr_i) begin
            // Abort keeps the last good receive word visible.
            state_q    <= IDLE;
            shreg_q    <= '0;
            dir_q      <= 1'b1;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_fire) begin
                        shreg_q <= ld_if.ld_data_i;
                        dir_q   <= ld_if.msb_first_i;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (beat) begin
                        shreg_q <= shreg_d;
                        if (cnt_last) begin
                            state_q    <= IDLE;
                            rx_data_q  <= shreg_d;
                            rx_valid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o           = (state_q == SHIFT);
    assign ld_if.ld_ready_o = (state_q == IDLE);
    assign ld_if.rx_valid_o = rx_valid_q;
    assign ld_if.rx_data_o  = rx_data_q;
    assign dout_o = !busy_o ? '0
                  : (dir_q ? shreg_q[SHIFT_W-1 -: LANES] : shreg_q[LANES-1:0]);
endmodule

// File: tb/tb_ste_shift_engine.sv
// tb/tb_ste_shift_engine.sv - scoreboard bench for ste_shift_engine (1-lane and 4-lane instances)
module tb_ste_shift_engine;
    logic       clk = 1'b0;
    logic       rst;
    logic       clr_a, en_a, loop_a, din_a_drv;
    logic       din_a, dout_a, busy_a;
    logic       clr_b, en_b, busy_b;
    logic [3:0] din_b, dout_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic        qa_dout[$];
    logic [23:0] qa_rx[$];
    logic [3:0]  qb_dout[$];
    logic [23:0] qb_rx[$];

    always #5 clk = ~clk;

    ste_shift_engine_if #(.SHIFT_W(24)) if_a ();
    ste_shift_engine_if #(.SHIFT_W(24)) if_b ();

    assign din_a = loop_a ? dout_a : din_a_drv;

    ste_shift_engine #(.SHIFT_W(24), .LANES(1)) u_a (
        .clk(clk), .reset_i(rst), .clr_i(clr_a), .shift_en_i(en_a),
        .din_i(din_a), .dout_o(dout_a), .busy_o(busy_a), .ld_if(if_a)
    );

    ste_shift_engine #(.SHIFT_W(24), .LANES(4)) u_b (
        .clk(clk), .reset_i(rst), .clr_i(clr_b), .shift_en_i(en_b),
        .din_i(din_b), .dout_o(dout_b), .busy_o(busy_b), .ld_if(if_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag_unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: output present with empty scoreboard at %0t", name, $time);
    endtask

    // Monitor: while busy, dout must match the head expectation (also during stalls); pop on each beat.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy_a) begin
                if (qa_dout.size() == 0) flag_unexpected("a_dout");
                else begin
                    check("a_dout", {31'd0, dout_a}, {31'd0, qa_dout[0]});
                    if (en_a) void'(qa_dout.pop_front());
                end
            end
            if (if_a.rx_valid_o) begin
                if (qa_rx.size() == 0) flag_unexpected("a_rx_valid");
                else check("a_rx_word", {8'd0, if_a.rx_data_o}, {8'd0, qa_rx.pop_front()});
            end
            if (busy_b) begin
                if (qb_dout.size() == 0) flag_unexpected("b_dout");
                else begin
                    check("b_dout", {28'd0, dout_b}, {28'd0, qb_dout[0]});
                    if (en_b) void'(qb_dout.pop_front());
                end
            end
            if (if_b.rx_valid_o) begin
                if (qb_rx.size() == 0) flag_unexpected("b_rx_valid");
                else check("b_rx_word", {8'd0, if_b.rx_data_o}, {8'd0, qb_rx.pop_front()});
            end
        end
    end

    task automatic check_reset_a(input string tag);
        check({tag, "_ready"}, {31'd0, if_a.ld_ready_o}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
        check({tag, "_dout"}, {31'd0, dout_a}, 32'd0);
        check({tag, "_rxv"}, {31'd0, if_a.rx_valid_o}, 32'd0);
        check({tag, "_rxd"}, {8'd0, if_a.rx_data_o}, 32'd0);
    endtask

    task automatic push_a(input logic [23:0] d, input bit msb);
        for (int i = 0; i < 24; i++) qa_dout.push_back(msb ? d[23-i] : d[i]);
    endtask

    // Loopback frame on the 1-lane engine; toggle stalls every other cycle starting with a stall.
    task automatic frame_a(input logic [23:0] d, input bit msb, input bit toggle, input int exp_cyc);
        int cyc;
        bit done;
        push_a(d, msb);
        qa_rx.push_back(d);
        loop_a = 1'b1;
        if_a.ld_data_i   = d;
        if_a.msb_first_i = msb;
        if_a.ld_valid_i  = 1'b1;
        en_a = 1'b0;
        @(posedge clk); #1;
        if_a.ld_valid_i = 1'b0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            en_a = toggle ? cyc[0] : 1'b1;
            @(posedge clk); #1;
            cyc++;
            done = if_a.rx_valid_o;
        end
        en_a = 1'b0;
        check("a_frame_cycles", cyc, exp_cyc);
        check("a_rx_data", {8'd0, if_a.rx_data_o}, {8'd0, d});
        @(posedge clk); #1;
        check("a_rx_pulse_width", {31'd0, if_a.rx_valid_o}, 32'd0);
    endtask

    initial begin
        int cyc;
        bit done;
        rst = 1'b1;
        clr_a = 1'b0; en_a = 1'b0; loop_a = 1'b0; din_a_drv = 1'b0;
        clr_b = 1'b0; en_b = 1'b0; din_b = 4'h0;
        if_a.ld_valid_i = 1'b0; if_a.ld_data_i = '0; if_a.msb_first_i = 1'b1;
        if_b.ld_valid_i = 1'b0; if_b.ld_data_i = '0; if_b.msb_first_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_a("reset_a");
        check("reset_b_ready", {31'd0, if_b.ld_ready_o}, 32'd1);
        check("reset_b_dout", {28'd0, dout_b}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        frame_a(24'hA5AA5A, 1'b1, 1'b0, 24);
        frame_a(24'hA5AA5A, 1'b0, 1'b0, 24);
        frame_a(24'hA5AA5A, 1'b1, 1'b1, 48);

        // Four lanes, MSB-first, constant all-ones input.
        qb_dout.push_back(4'h2); qb_dout.push_back(4'h3); qb_dout.push_back(4'h4);
        qb_dout.push_back(4'h5); qb_dout.push_back(4'h6); qb_dout.push_back(4'h7);
        qb_rx.push_back(24'hFFFFFF);
        din_b = 4'hF;
        if_b.ld_data_i = 24'h234567; if_b.msb_first_i = 1'b1; if_b.ld_valid_i = 1'b1;
        @(posedge clk); #1;
        if_b.ld_valid_i = 1'b0;
        en_b = 1'b1;
        cyc = 0; done = 1'b0;
        while (!done && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            done = if_b.rx_valid_o;
        end
        en_b = 1'b0;
        check("b_frame_cycles", cyc, 6);
        check("b_rx_data", {8'd0, if_b.rx_data_o}, 32'h00FFFFFF);

        // Clear after beat 10 of a second frame; earlier receive word must survive.
        frame_a(24'h111111, 1'b1, 1'b0, 24);
        push_a(24'hDFEABC, 1'b1);
        if_a.ld_data_i = 24'hDFEABC; if_a.msb_first_i = 1'b1; if_a.ld_valid_i = 1'b1;
        @(posedge clk); #1;
        if_a.ld_valid_i = 1'b0;
        en_a = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        clr_a = 1'b1;
        @(posedge clk); #1;
        clr_a = 1'b0; en_a = 1'b0;
        qa_dout.delete();
        check("clr_busy", {31'd0, busy_a}, 32'd0);
        check("clr_ready", {31'd0, if_a.ld_ready_o}, 32'd1);
        check("clr_rx_valid", {31'd0, if_a.rx_valid_o}, 32'd0);
        check("clr_rx_data", {8'd0, if_a.rx_data_o}, 32'h00111111);
        repeat (3) begin @(posedge clk); #1; end
        check("clr_rx_data_held", {8'd0, if_a.rx_data_o}, 32'h00111111);

        // Load request held during a frame, then reset mid-frame.
        push_a(24'h0F0F0F, 1'b1);
        if_a.ld_data_i = 24'h0F0F0F; if_a.msb_first_i = 1'b1; if_a.ld_valid_i = 1'b1;
        @(posedge clk); #1;
        if_a.ld_data_i = 24'h777777; if_a.msb_first_i = 1'b0;
        en_a = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("held_ld_ready", {31'd0, if_a.ld_ready_o}, 32'd0);
        end
        rst = 1'b1; if_a.ld_valid_i = 1'b0; en_a = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        qa_dout.delete();
        check_reset_a("midreset_a");
        repeat (3) begin @(posedge clk); #1; end
        check("midreset_rx_valid", {31'd0, if_a.rx_valid_o}, 32'd0);

        check("a_rx_outstanding", qa_rx.size(), 0);
        check("b_rx_outstanding", qb_rx.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
